// File: rtl/prog_instr_mem_pkg.sv
// Shared definitions for the program instruction memory.
//   state_t     : controller state (IDLE, LOAD, RUN)
//   NOP_DEFAULT : default word returned on a faulted fetch
package prog_instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [15:0] NOP_DEFAULT = 16'h0000;

endpackage

// File: rtl/imem_sp_ram.sv
// Single-port synchronous RAM, DEPTH x DATA_W, no reset.
//   clk   : rising-edge clock
//   we    : write wdata to mem[addr]
//   re    : capture mem[addr] into rdata (registered read)
//   addr  : shared word address
//   wdata : write data
//   rdata : registered read data; holds while re is low
module imem_sp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/prog_instr_mem.sv
// Loadable program memory with a fetch port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_start  : enter LOAD and clear the write pointer
//   load_valid  : load_data is written at the pointer this cycle
//   load_data   : program word
//   load_end    : leave LOAD, latch prog_len from the pointer
//   fetch_req   : fetch request, fetch_addr is the word address
//   fetch_rdy   : request accepted this cycle (RUN only)
//   instr       : fetched word, NOP_WORD on a fault
//   instr_valid : instr / addr_err valid; held until instr_ready
//   instr_ready : consumer takes instr
//   addr_err    : fetch address was at or beyond prog_len
//   prog_len    : number of loaded words
//   load_full   : write pointer has reached DEPTH
module prog_instr_mem
  import prog_instr_mem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DEPTH    = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_end,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rdy,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              addr_err,
  output logic [ADDR_W:0]   prog_len,
  output logic              load_full
);

  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W:0]   len_q;
  logic              valid_q;
  logic              err_q;
  logic              nop_q;
  logic              wr_en;
  logic              accept;
  logic              fault;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // Next-state logic; load_start wins over load_end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (load_start) state_d = LOAD;
               else if (load_end) state_d = RUN;
      RUN:     if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A load_start in RUN flushes the response path, so no new fetch is
  // accepted in that cycle.
  assign fetch_rdy = (state_q == RUN) && !load_start && (!valid_q || instr_ready);
  assign accept    = fetch_rdy && fetch_req;
  assign fault     = {1'b0, fetch_addr} >= len_q;
  assign wr_en     = (state_q == LOAD) && !load_start && load_valid && (ptr_q < DEPTH_L);
  // Single port: the write pointer owns the address during LOAD.
  assign ram_addr  = (state_q == LOAD) ? ptr_q[AW-1:0] : fetch_addr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      len_q <= '0;
    end else begin
      if (load_start) ptr_q <= '0;
      else if (wr_en) ptr_q <= ptr_q + 1'b1;
      // A word written alongside load_end is counted.
      if ((state_q == LOAD) && !load_start && load_end)
        len_q <= wr_en ? ptr_q + 1'b1 : ptr_q;
    end
  end

  // Response register. nop_q selects NOP_WORD over the RAM output, which
  // also covers the reset value since the RAM read register is not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      nop_q   <= 1'b1;
    end else if (load_start) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      err_q   <= fault;
      nop_q   <= fault;
    end else if (instr_ready) begin
      valid_q <= 1'b0;
    end
  end

  imem_sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .re    (accept),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  assign instr       = nop_q ? NOP_WORD : ram_rdata;
  assign instr_valid = valid_q;
  assign addr_err    = err_q;
  assign prog_len    = len_q;
  assign load_full   = (ptr_q == DEPTH_L);

endmodule

// File: tb/tb_prog_instr_mem.sv
module tb_prog_instr_mem;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned DP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start, load_valid, load_end;
  logic [DW-1:0] load_data;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_rdy;
  logic [DW-1:0] instr;
  logic          instr_valid, instr_ready, addr_err;
  logic [AW:0]   prog_len;
  logic          load_full;

  prog_instr_mem #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DP),
    .NOP_WORD (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_end    (load_end),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_rdy   (fetch_rdy),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .addr_err    (addr_err),
    .prog_len    (prog_len),
    .load_full   (load_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
  endtask

  // Reference model: program image, load pointer, length, mode, pending flag.
  typedef struct {
    logic [DW-1:0] w;
    logic          e;
  } resp_t;
  resp_t         sbq[$];
  logic [DW-1:0] mmem [DP];
  int unsigned   mptr, mlen;
  int            mmode;   // 0 idle, 1 loading, 2 running
  bit            mvalid;
  bit            last_acc;

  task automatic model_reset();
    mptr = 0; mlen = 0; mmode = 0; mvalid = 0;
  endtask

  task automatic model_update(input bit acc);
    resp_t r;
    if (acc) begin
      r.e = (int'(fetch_addr) >= mlen);
      r.w = r.e ? 16'h0000 : mmem[fetch_addr];
      sbq.push_back(r);
    end
    if (mmode == 2 && load_start) mvalid = 0;
    else if (acc)                 mvalid = 1;
    else if (instr_ready)         mvalid = 0;
    if (load_start) begin
      mmode = 1; mptr = 0;
    end else if (mmode == 1) begin
      if (load_valid && mptr < DP) begin
        mmem[mptr] = load_data;
        mptr++;
      end
      if (load_end) begin
        mlen = mptr; mmode = 2;
      end
    end
  endtask

  // One clock: predict and check control outputs at negedge, then apply the
  // edge to the model just after the posedge.
  task automatic step();
    bit exp_rdy;
    exp_rdy = 0;
    @(negedge clk);
    if (rst_n) begin
      exp_rdy = (mmode == 2) && !load_start && (!mvalid || instr_ready);
      chk("fetch_rdy", fetch_rdy, exp_rdy);
      chk("load_full", load_full, mptr == DP);
      chk("prog_len",  prog_len,  mlen);
    end
    last_acc = rst_n && exp_rdy && fetch_req;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_update(last_acc);
  endtask

  // Monitor: every presented response is compared to the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) sbq.delete();
    else begin
      chk("instr_valid", instr_valid, sbq.size() != 0);
      if (instr_valid && sbq.size() != 0) begin
        chk("instr",    instr,    sbq[0].w);
        chk("addr_err", addr_err, sbq[0].e);
        if (instr_ready || load_start) void'(sbq.pop_front());
      end
    end
  end

  task automatic check_reset();
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr",       instr,       16'h0000);
    chk("rst_addr_err",    addr_err,    0);
    chk("rst_fetch_rdy",   fetch_rdy,   0);
    chk("rst_load_full",   load_full,   0);
    chk("rst_prog_len",    prog_len,    0);
  endtask

  task automatic load_words(input logic [DW-1:0] w[$]);
    load_start = 1; step(); load_start = 0;
    foreach (w[i]) begin
      load_valid = 1; load_data = w[i]; step();
    end
    load_valid = 0; load_end = 1; step(); load_end = 0;
  endtask

  // Retries until accepted with a random instr_ready; bounded.
  task automatic fetch(input int addr, input bit rnd_ready);
    int tries;
    tries = 0;
    fetch_req = 1; fetch_addr = AW'(addr);
    do begin
      instr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      tries++;
    end while (!last_acc && tries < 20);
    if (!last_acc) chk("fetch_accept_timeout", 0, 1);
    fetch_req = 0;
  endtask

  task automatic drain();
    fetch_req = 0; instr_ready = 1;
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w[$];
    rst_n = 0; load_start = 0; load_valid = 0; load_end = 0; load_data = '0;
    fetch_req = 0; fetch_addr = '0; instr_ready = 0;
    model_reset();
    #1 check_reset();
    repeat (2) step();
    rst_n = 1;
    step();

    // Basic load and back-to-back fetches, then an out-of-range fetch.
    w = '{16'h2009, 16'h200A, 16'h012A};
    load_words(w);
    chk("prog_len_3", prog_len, 3);
    instr_ready = 1; fetch_req = 1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = AW'(i); step();
      chk("b2b_accept", last_acc, 1);
    end
    drain();

    // Stall: response must hold while instr_ready is low.
    fetch_req = 1; fetch_addr = 1; instr_ready = 1; step();
    fetch_addr = 2; instr_ready = 0;
    repeat (4) step();
    instr_ready = 1; step();
    chk("stall_release_accept", last_acc, 1);
    drain();

    // Overfill: 9 words into depth 8.
    w = {};
    for (int i = 0; i < 9; i++) w.push_back(DW'($urandom));
    load_words(w);
    chk("prog_len_full", prog_len, 8);
    chk("load_full_set", load_full, 1);
    for (int i = 0; i < 9; i++) fetch(i, 1);
    drain();

    // Reset mid-load, between clock edges.
    load_start = 1; step(); load_start = 0;
    load_valid = 1; load_data = 16'h1111; step();
    load_data = 16'h2222; step();
    #2 rst_n = 0;
    #1 check_reset();
    model_reset();
    load_valid = 0;
    step();
    rst_n = 1;
    fetch_req = 1; fetch_addr = 0; instr_ready = 1;
    repeat (3) step();
    fetch_req = 0;
    w = '{16'h3333, 16'h4444};
    load_words(w);
    fetch(0, 0); fetch(1, 0); fetch(2, 0);
    drain();

    // load_start while a response is pending, then reload one word.
    fetch_req = 1; fetch_addr = 0; instr_ready = 0; step();
    fetch_req = 0;
    w = '{16'h014B};
    load_words(w);
    fetch(0, 0); fetch(1, 0);
    drain();

    // load_start together with load_end: pointer restarts, length kept.
    load_start = 1; step(); load_start = 0;
    load_valid = 1; load_data = 16'h5555; step();
    load_valid = 0; load_start = 1; load_end = 1; step();
    load_start = 0; load_end = 0;
    load_valid = 1; load_data = 16'h6666; load_end = 1; step();
    load_valid = 0; load_end = 0;
    fetch(0, 0); fetch(1, 0);
    drain();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      load_start  = ($urandom_range(0, 99) < 4);
      load_end    = ($urandom_range(0, 99) < 15);
      load_valid  = !load_start && ($urandom_range(0, 1) == 1);
      load_data   = DW'($urandom);
      fetch_req   = ($urandom_range(0, 99) < 70);
      fetch_addr  = AW'($urandom_range(0, 10));
      instr_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    load_start = 0; load_end = 0; load_valid = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
